// File: rtl/operand_loader.sv
// operand_loader: assembles NUM_OPS operands of BITLEN bits from a byte stream, commits them, finds operand 0's top set bit, then writes each operand to BRAM.
// Optional macro CHECKSUM_EN appends a trailing XOR byte to each frame; tx_valid is withheld while busy_in is high.
module operand_loader #(
  parameter int BITLEN         = 256,
  parameter int NUM_OPS        = 2,
  parameter int ABITS          = 8,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int MSB_FIRST      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  input  logic                        busy_in,
  output logic [NUM_OPS*BITLEN-1:0]   op_bus,
  output logic [$clog2(BITLEN)-1:0]   msb_idx,
  output logic                        tx_valid,
  output logic [ABITS-1:0]            wr_addr,
  output logic [BITLEN-1:0]           wr_data,
  output logic                        wr_en,
  output logic                        frame_err,
  output logic                        load_active
);
  localparam int OPB = BITLEN / 8;
  localparam int F   = NUM_OPS * OPB;
`ifdef CHECKSUM_EN
  localparam int FT  = F + 1;
`else
  localparam int FT  = F;
`endif
  localparam int MW  = $clog2(BITLEN);
  localparam int CW  = $clog2(FT + 1);
  localparam int OW  = $clog2(OPB + 1);
  localparam int NW  = $clog2(NUM_OPS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, SCAN, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_OPS*BITLEN-1:0] staging;
  logic [BITLEN-1:0]         op0;
  logic [CW-1:0]             byte_cnt;
  logic [OW-1:0]             byte_idx;
  logic [NW-1:0]             op_idx;
  logic [TW-1:0]             idle_cnt;
  logic [MW-1:0]             bit_idx;
  logic                      timeout, last_byte, scan_stop, write_last, chk_ok;
  logic                      take_byte, drop_byte, commit;
  int                        byte_pos, stage_base;

  assign op0         = op_bus[BITLEN-1:0];
  assign load_active = (state != IDLE);
  assign timeout     = (TIMEOUT_CYCLES != 0) && (state == RECV) &&
                       ((32'(idle_cnt) + 32'd1) == TIMEOUT_CYCLES);
  assign last_byte   = (32'(byte_cnt) == FT - 1);
  assign scan_stop   = op0[bit_idx] || (bit_idx == '0);
  assign write_last  = (32'(wr_addr) == NUM_OPS - 1);

  always_comb begin
    byte_pos   = (MSB_FIRST != 0) ? (OPB - 1 - int'(byte_idx)) : int'(byte_idx);
    stage_base = int'(op_idx) * BITLEN + byte_pos * 8;
  end

`ifdef CHECKSUM_EN
  logic [7:0] xor_acc, chk_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_acc  <= '0;
      chk_byte <= '0;
    end else if (take_byte) begin
      if (32'(byte_cnt) < F) xor_acc <= (state == IDLE) ? rx_byte : (xor_acc ^ rx_byte);
      else                   chk_byte <= rx_byte;
    end
  end

  assign chk_ok = (xor_acc == chk_byte);
`else
  assign chk_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_byte = 1'b0;
    drop_byte = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        take_byte = 1'b1;
        state_nxt = RECV;
      end
      // A byte landing on the timeout cycle is discarded along with the frame.
      RECV: if (timeout) begin
        state_nxt = IDLE;
      end else if (rx_valid) begin
        take_byte = 1'b1;
        if (last_byte) state_nxt = CHECK;
      end
      CHECK: if (chk_ok) begin
        commit    = 1'b1;
        state_nxt = SCAN;
      end else begin
        state_nxt = IDLE;
      end
      SCAN:    if (scan_stop) state_nxt = WRITE;
      WRITE:   if (write_last) state_nxt = DONE;
      DONE:    if (!busy_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rx_valid && (state inside {CHECK, SCAN, WRITE, DONE})) drop_byte = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      staging   <= '0;
      op_bus    <= '0;
      byte_cnt  <= '0;
      byte_idx  <= '0;
      op_idx    <= '0;
      idle_cnt  <= '0;
      bit_idx   <= '0;
      msb_idx   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout || drop_byte || ((state == CHECK) && !chk_ok);
      tx_valid  <= (state == DONE) && !busy_in;

      // Counters are zero whenever the FSM sits in IDLE, so the first byte lands at position 0.
      if (take_byte) begin
        if (32'(byte_cnt) < F) staging[stage_base +: 8] <= rx_byte;
        byte_cnt <= byte_cnt + 1'b1;
        if (32'(byte_idx) == OPB - 1) begin
          byte_idx <= '0;
          op_idx   <= op_idx + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (state_nxt != RECV) begin
        byte_cnt <= '0;
        byte_idx <= '0;
        op_idx   <= '0;
      end

      if (take_byte || state_nxt != RECV) idle_cnt <= '0;
      else if (TIMEOUT_CYCLES != 0)       idle_cnt <= idle_cnt + 1'b1;

      if (timeout) staging <= '0;

      if (commit) begin
        op_bus  <= staging;
        bit_idx <= MW'(BITLEN - 1);
      end

      // bit_idx is already 0 when nothing was found, so it doubles as the all-zero result.
      if (state == SCAN) begin
        if (scan_stop) begin
          msb_idx <= bit_idx;
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= op0;
        end else begin
          bit_idx <= bit_idx - 1'b1;
        end
      end

      if (state == WRITE) begin
        if (write_last) begin
          wr_en <= 1'b0;
        end else begin
          wr_addr <= wr_addr + 1'b1;
          wr_data <= op_bus[(32'(wr_addr) + 32'd1) * BITLEN +: BITLEN];
        end
      end
    end
  end
endmodule
